// File: rtl/avalon_st_sink_interface.sv
// Avalon-ST sink front end: registered-ready 2-entry skid buffer plus SOP/EOP framing and status.
// Optional length checking (len_err, err_count) is built only when SINK_FRAME_CHECK_EN is defined.
module avalon_st_sink_interface #(
    parameter int DATA_W       = 16,
    parameter int FRAME_PIXELS = 76800,
    parameter int CNT_W        = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              frame_done,
    output logic [CNT_W-1:0]  pixel_count,
    output logic              len_err,
    output logic [7:0]        err_count
);

    typedef enum logic {IDLE, PKT} state_t;
    state_t state_q, state_d;

    logic              m_valid, m_sop, m_eop;
    logic [DATA_W-1:0] m_data;
    logic              s_valid, s_sop, s_eop;
    logic [DATA_W-1:0] s_data;

    logic              m_valid_d, m_sop_d, m_eop_d;
    logic [DATA_W-1:0] m_data_d;
    logic              s_valid_d, s_sop_d, s_eop_d;
    logic [DATA_W-1:0] s_data_d;

    logic              accept, keep;
    logic [CNT_W-1:0]  cnt_d;
    logic              done_d;
    logic              len_err_d;

    assign accept = in_valid & in_ready;
    // Beats outside a packet are handshaken but never buffered.
    assign keep   = accept & (in_sop | (state_q == PKT));

    // Skid buffer next state; in_ready is low whenever S holds a beat, so S and input never collide.
    always_comb begin
        m_valid_d = m_valid;
        m_sop_d   = m_sop;
        m_eop_d   = m_eop;
        m_data_d  = m_data;
        s_valid_d = s_valid;
        s_sop_d   = s_sop;
        s_eop_d   = s_eop;
        s_data_d  = s_data;
        if (s_valid) begin
            if (out_ready) begin
                m_valid_d = 1'b1;
                m_sop_d   = s_sop;
                m_eop_d   = s_eop;
                m_data_d  = s_data;
                s_valid_d = 1'b0;
            end
        end else if (keep) begin
            if (!m_valid || out_ready) begin
                m_valid_d = 1'b1;
                m_sop_d   = in_sop;
                m_eop_d   = in_eop;
                m_data_d  = in_data;
            end else begin
                s_valid_d = 1'b1;
                s_sop_d   = in_sop;
                s_eop_d   = in_eop;
                s_data_d  = in_data;
            end
        end else if (m_valid && out_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_sop    <= 1'b0;
            m_eop    <= 1'b0;
            m_data   <= '0;
            s_valid  <= 1'b0;
            s_sop    <= 1'b0;
            s_eop    <= 1'b0;
            s_data   <= '0;
            in_ready <= 1'b0;
        end else begin
            m_valid  <= m_valid_d;
            m_sop    <= m_sop_d;
            m_eop    <= m_eop_d;
            m_data   <= m_data_d;
            s_valid  <= s_valid_d;
            s_sop    <= s_sop_d;
            s_eop    <= s_eop_d;
            s_data   <= s_data_d;
            in_ready <= ~s_valid_d;
        end
    end

    assign out_valid = m_valid;
    assign out_sop   = m_sop;
    assign out_eop   = m_eop;
    assign out_data  = m_data;

    // Framing FSM: next state, count and status pulses for the beat accepted this cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = pixel_count;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        if (keep) begin
            if (in_sop) begin
                cnt_d = CNT_W'(1);
`ifdef SINK_FRAME_CHECK_EN
                if (state_q == PKT) len_err_d = 1'b1;
`endif
            end else if (pixel_count != '1) begin
                cnt_d = pixel_count + CNT_W'(1);
            end
            if (in_eop) begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef SINK_FRAME_CHECK_EN
                if (cnt_d != CNT_W'(FRAME_PIXELS)) len_err_d = 1'b1;
`endif
            end else begin
                state_d = PKT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pixel_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_count <= cnt_d;
            frame_done  <= done_d;
        end
    end

`ifdef SINK_FRAME_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            len_err   <= 1'b0;
            err_count <= '0;
        end else begin
            len_err <= len_err_d;
            if (len_err_d && err_count != '1) err_count <= err_count + 8'd1;
        end
    end
`else
    assign len_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule
